// File: rtl/msrv32_pc_fetch_pkg.sv
// ============================================================================
// Module   : msrv32_pc_fetch_pkg
// Brief    : Shared encodings for the fetch stage (PC source, NOP, FSM states)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package msrv32_pc_fetch_pkg;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_RUN   = 2'd1;
    localparam fetch_state_t ST_WAIT  = 2'd2;
    localparam fetch_state_t ST_FLUSH = 2'd3;

endpackage

`default_nettype wire

// File: rtl/msrv32_pc_mux.sv
// ============================================================================
// Module   : msrv32_pc_mux
// Brief    : Combinational next-PC selection with redirect/misalign decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_pc_mux #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc_out,
    output logic        redirect_out,
    output logic        misaligned_out
);
    import msrv32_pc_fetch_pkg::*;

    logic [31:0] w_branch_target;

    // Bit 0 of a jump target is architecturally ignored (JALR semantics)
    assign w_branch_target = iaddr_in & ~32'h0000_0001;

    always_comb begin
        next_pc_out = pc_in + 32'd4;
        case (pc_src_in)
            PC_SRC_BOOT: next_pc_out = BOOT_ADDRESS;
            PC_SRC_EPC:  next_pc_out = epc_in;
            PC_SRC_TRAP: next_pc_out = trap_address_in;
            default: begin
                if (branch_taken_in) begin
                    next_pc_out = w_branch_target;
                end
            end
        endcase
    end

    assign misaligned_out = (pc_src_in == PC_SRC_NEXT) & branch_taken_in & iaddr_in[1];
    assign redirect_out   = (pc_src_in != PC_SRC_NEXT) | (branch_taken_in & ~iaddr_in[1]);

endmodule

`default_nettype wire

// File: rtl/msrv32_pc_fetch.sv
// ============================================================================
// Module   : msrv32_pc_fetch
// Brief    : RV32 fetch stage: PC register, fetch FSM, flush/NOP insertion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msrv32_pc_fetch #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = msrv32_pc_fetch_pkg::NOP_INSTR
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iaddr_in,
    input  logic [1:0]  pc_src_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        instr_hready_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] iaddr_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic        misaligned_instr_out,
    output logic        flush_out
);
    import msrv32_pc_fetch_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         r_misaligned;
    logic         w_misaligned_next;

    logic [31:0]  w_mux_pc;
    logic         w_redirect;
    logic         w_misaligned_branch;
    logic         w_issue;

    msrv32_pc_mux #(
        .BOOT_ADDRESS (BOOT_ADDRESS)
    ) u_pc_mux (
        .pc_src_in       (pc_src_in),
        .branch_taken_in (branch_taken_in),
        .iaddr_in        (iaddr_in),
        .epc_in          (epc_in),
        .trap_address_in (trap_address_in),
        .pc_in           (r_pc),
        .next_pc_out     (w_mux_pc),
        .redirect_out    (w_redirect),
        .misaligned_out  (w_misaligned_branch)
    );

    // An instruction is handed to decode only in RUN/WAIT with memory ready
    assign w_issue = ((r_state == ST_RUN) | (r_state == ST_WAIT)) & instr_hready_in;

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_misaligned_next = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                if (!instr_hready_in) begin
                    w_state_next = ST_WAIT;
                end else if (w_misaligned_branch) begin
                    // Hold the PC and flag the fault; the trap logic redirects later
                    w_misaligned_next = 1'b1;
                    w_state_next      = ST_RUN;
                end else begin
                    w_pc_next    = w_mux_pc;
                    w_state_next = w_redirect ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (instr_hready_in) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state      <= ST_BOOT;
            r_pc         <= BOOT_ADDRESS;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    // The fetch address is the value the PC register will take next
    assign iaddr_out            = w_pc_next;
    assign pc_out               = r_pc;
    assign pc_plus_4_out        = r_pc + 32'd4;
    assign instr_valid_out      = w_issue;
    assign instr_out            = w_issue ? instr_in : NOP_INSTR;
    assign misaligned_instr_out = r_misaligned;
    assign flush_out            = (r_state == ST_FLUSH);

endmodule

`default_nettype wire

// File: doc/msrv32_pc_fetch.md
MSRV32_PC_FETCH -- requirements
Module: msrv32_pc_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000, PC loaded on reset and on pc_src_in=2'b00.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction substituted during flush.
REQ-003 ms_riscv32_mp_clk_in  input  1  single clock; all state on rising edge.
REQ-004 ms_riscv32_mp_rst_in  input  1  reset; synchronous, active-high.
REQ-005 branch_taken_in  input  1  branch/jump decision from branch unit for current instruction.
REQ-006 iaddr_in  input  32  branch/jump target from immediate adder.
REQ-007 pc_src_in  input  2  PC source: 00 boot, 01 epc, 10 trap, 11 next.
REQ-008 epc_in  input  32  return address for mret.
REQ-009 trap_address_in  input  32  trap vector address.
REQ-010 instr_hready_in  input  1  instruction memory ready; low = stall.
REQ-011 instr_in  input  32  instruction data from memory for pc_out.
REQ-012 pc_out  output  32  registered PC of instruction in decode.
REQ-013 iaddr_out  output  32  fetch address to memory, combinational next PC.
REQ-014 pc_plus_4_out  output  32  pc_out + 4, for JAL/JALR link.
REQ-015 instr_out  output  32  instruction to decode (NOP_INSTR when not valid).
REQ-016 instr_valid_out  output  1  instr_out is a real instruction.
REQ-017 misaligned_instr_out  output  1  taken target has iaddr_in[1]=1; registered.
REQ-018 flush_out  output  1  high in FLUSH state; pipeline squash.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, WAIT, FLUSH.
REQ-020 BOOT: one cycle; pc_out=BOOT_ADDRESS, instr_valid_out=0; next RUN unconditionally.
REQ-021 Next-PC priority: pc_src_in 00 -> BOOT_ADDRESS; 01 -> epc_in; 10 -> trap_address_in; 11 -> branch_taken_in ? {iaddr_in[31:1],1'b0} : pc_out+4.
REQ-022 Redirect = (pc_src_in!=2'b11) | (branch_taken_in & ~iaddr_in[1]); pc_src trap/epc/boot SHALL override branch_taken_in when simultaneous.
REQ-023 RUN, instr_hready_in=1: pc_out<=next PC; instr_out=instr_in, instr_valid_out=1; redirect -> FLUSH, else stay RUN.
REQ-024 RUN/WAIT, instr_hready_in=0: pc_out held, instr_valid_out=0, instr_out=NOP_INSTR; go/stay WAIT; redirect requests ignored until ready.
REQ-025 WAIT, instr_hready_in=1: behave exactly as RUN with ready (REQ-023).
REQ-026 FLUSH: instr_out=NOP_INSTR, instr_valid_out=0, flush_out=1, pc_out held at target; next RUN if instr_hready_in=1, else stay FLUSH.
REQ-027 iaddr_out SHALL equal pc_out while pc_out is held, else the next PC; always 32-bit, pc+4 wraps modulo 2^32.
REQ-028 branch_taken_in with pc_src_in=11 and iaddr_in[1]=1: pc_out held, no redirect, misaligned_instr_out=1 for exactly the next cycle.
REQ-029 Latency: redirect target appears on pc_out one cycle after request; first target instruction valid two cycles after request.

Reset
REQ-030 Reset SHALL take effect on clock edge with ms_riscv32_mp_rst_in=1, from any state including WAIT/FLUSH.
REQ-031 Reset values: state BOOT, pc_out=BOOT_ADDRESS, instr_valid_out=0, misaligned_instr_out=0, flush_out=0, instr_out=NOP_INSTR.

Structure
REQ-032 Shared package SHALL hold PC_SRC_* encodings (BOOT/EPC/TRAP/NEXT), NOP_INSTR constant and FSM state typedef.
REQ-033 Next-PC mux SHALL be sub-module msrv32_pc_mux (combinational); FSM and registers in top.

Verification
REQ-034 Reset 3 cycles, release, hready=1, pc_src=11, no branch -> pc_out 0,4,8,C; instr_valid_out=0 in BOOT then 1.
REQ-035 At pc_out=0x10 assert branch_taken, iaddr=0x100 -> next cycle pc_out=0x100, flush_out=1, instr_out=0x00000013; following cycle valid=1.
REQ-036 iaddr=0x102 with branch_taken -> pc_out held, misaligned_instr_out=1 one cycle, no flush.
REQ-037 hready=0 for 3 cycles at pc_out=0x20 with branch_taken -> pc_out stays 0x20, valid=0; on ready redirect proceeds to target.
REQ-038 pc_src=10, trap_address=0x400 with branch_taken, iaddr=0x100 same cycle -> pc_out=0x400.
REQ-039 Reset asserted during FLUSH -> next cycle state BOOT, pc_out=BOOT_ADDRESS, flush_out=0.
